// File: rtl/motoro3_pwm_generator_if.sv
// Bridge-enable / step-counter bundle into the PWM chopper and the registered pwm back out.
// master drives the step-decoder side, slave is the chopper.
interface motoro3_pwm_generator_if;
  logic        aE;
  logic        bE;
  logic        cE;
  logic [24:0] m3cnt;
  logic        m3cntLast1;
  logic        pwm;

  modport master (output aE, bE, cE, m3cnt, m3cntLast1, input pwm);
  modport slave  (input aE, bE, cE, m3cnt, m3cntLast1, output pwm);
endinterface

// File: rtl/motoro3_pwm_generator.sv
// PWM chopper for the 3-phase bridge: free-running period counter gated by enable-change blanking and end-of-step guard.
// One falling-edge clk of latency to the flop-driven pwm; no backpressure, inputs are sampled every cycle.
module motoro3_pwm_generator #(
  parameter int unsigned PERIOD = 100,
  parameter int unsigned DUTY   = 50,
  parameter int unsigned DEAD   = 10,
  parameter int unsigned GUARD  = 2
) (
  input  logic                    clk,
  input  logic                    nRst,
  motoro3_pwm_generator_if.slave  pwm_if
);

  localparam logic [15:0] PCNT_MAX = 16'(PERIOD - 1);
  localparam logic [16:0] DUTY_W   = 17'(DUTY);
  localparam logic [15:0] DEAD_W   = 16'(DEAD);
  localparam logic [24:0] GUARD_W  = 25'(GUARD);

  logic [15:0] pcnt;
  logic [15:0] dead_cnt;
  logic [2:0]  en_prev;
  logic [2:0]  en_now;
  logic        duty_hit;
  logic        pwm_next;
  logic        pwm_q;

  assign en_now = {pwm_if.aE, pwm_if.bE, pwm_if.cE};

  // pcnt < DUTY written as pcnt+1 <= DUTY so DUTY = 0 does not fold to a constant compare
  assign duty_hit = (({1'b0, pcnt} + 17'd1) <= DUTY_W);

  always_comb begin
    pwm_next = 1'b0;
    if ((en_now != 3'b000) && duty_hit && (dead_cnt == 16'd0) &&
        !pwm_if.m3cntLast1 && (pwm_if.m3cnt > GUARD_W)) begin
      pwm_next = 1'b1;
    end
  end

  always_ff @(negedge clk or posedge nRst) begin
    if (nRst) begin
      pcnt     <= 16'd0;
      dead_cnt <= 16'd0;
      en_prev  <= 3'b000;
      pwm_q    <= 1'b0;
    end else begin
      pcnt    <= (pcnt >= PCNT_MAX) ? 16'd0 : pcnt + 16'd1;
      en_prev <= en_now;
      pwm_q   <= pwm_next;
      // any enable change, including one during blanking, restarts the blanking window
      if (en_now != en_prev) begin
        dead_cnt <= DEAD_W;
      end else if (dead_cnt != 16'd0) begin
        dead_cnt <= dead_cnt - 16'd1;
      end
    end
  end

  assign pwm_if.pwm = pwm_q;

endmodule

// File: tb/tb_motoro3_pwm_generator.sv
// Bench for motoro3_pwm_generator: directed scenarios plus random enables/step counts against a cycle-index reference model.
`timescale 1ns/1ps
module tb_motoro3_pwm_generator;
  localparam int PERIOD = 100;
  localparam int DEAD   = 10;
  localparam int GUARD  = 2;

  logic clk = 1'b1;
  logic nRst;
  always #50 clk = ~clk;

  motoro3_pwm_generator_if if_d ();
  motoro3_pwm_generator_if if_z ();
  motoro3_pwm_generator_if if_f ();

  motoro3_pwm_generator #(.PERIOD(PERIOD), .DUTY(50),  .DEAD(DEAD), .GUARD(GUARD))
    u_dut_d (.clk(clk), .nRst(nRst), .pwm_if(if_d));
  motoro3_pwm_generator #(.PERIOD(PERIOD), .DUTY(0),   .DEAD(DEAD), .GUARD(GUARD))
    u_dut_z (.clk(clk), .nRst(nRst), .pwm_if(if_z));
  motoro3_pwm_generator #(.PERIOD(PERIOD), .DUTY(100), .DEAD(DEAD), .GUARD(GUARD))
    u_dut_f (.clk(clk), .nRst(nRst), .pwm_if(if_f));

  int checks = 0;
  int passed = 0;

  logic [2:0]  cur_en;
  logic [24:0] cur_cnt;
  logic        cur_last;
  logic        exp_d, exp_z, exp_f;

  // reference state: edge index since reset, edge of latest enable change, enable seen at previous edge
  int          mn;
  int          last_chg;
  logic [2:0]  prev_en;

  logic [2:0]  pats [0:6] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b101, 3'b011, 3'b110};

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, expv, $time);
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic drive();
    {if_d.aE, if_d.bE, if_d.cE} = cur_en;
    {if_z.aE, if_z.bE, if_z.cE} = cur_en;
    {if_f.aE, if_f.bE, if_f.cE} = cur_en;
    if_d.m3cnt = cur_cnt;  if_z.m3cnt = cur_cnt;  if_f.m3cnt = cur_cnt;
    if_d.m3cntLast1 = cur_last;  if_z.m3cntLast1 = cur_last;  if_f.m3cntLast1 = cur_last;
  endtask

  function automatic logic ref_pwm(input int duty, input bit blank);
    return (cur_en != 3'b000) && ((mn % PERIOD) < duty) && !blank &&
           !cur_last && (cur_cnt > 25'(GUARD));
  endfunction

  task automatic model_reset();
    mn = 0;
    last_chg = -1000000;
    prev_en = 3'b000;
    exp_d = 1'b0;  exp_z = 1'b0;  exp_f = 1'b0;
  endtask

  // blanked while fewer than DEAD+1 edges have passed since the last enable change
  task automatic model_step();
    bit blank;
    blank = (mn - last_chg) <= DEAD;
    exp_d = ref_pwm(50, blank);
    exp_z = ref_pwm(0, blank);
    exp_f = ref_pwm(100, blank);
    if (cur_en != prev_en) last_chg = mn;
    prev_en = cur_en;
    mn++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_d50"},  if_d.pwm, exp_d);
    chk({tag, "_d0"},   if_z.pwm, exp_z);
    chk({tag, "_d100"}, if_f.pwm, exp_f);
  endtask

  task automatic cyc(input logic [2:0] en, input logic [24:0] cnt, input logic last1);
    @(posedge clk);
    check_all("pwm");
    cur_en = en;  cur_cnt = cnt;  cur_last = last1;
    drive();
    model_step();
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    check_all("pre_rst");
    nRst = 1'b1;
    #1;
    chk("rst_async_d50",  if_d.pwm, 1'b0);
    chk("rst_async_d100", if_f.pwm, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    chk("rst_hold_d50",  if_d.pwm, 1'b0);
    chk("rst_hold_d100", if_f.pwm, 1'b0);
    nRst = 1'b0;
    model_step();
  endtask

  // run steady until the next edge lands on the requested period phase
  task automatic align(input logic [2:0] en, input int phase);
    for (int k = 0; k < 2 * PERIOD && (mn % PERIOD) != phase; k++) cyc(en, 25'd1000, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hd, hz, hf;
    nRst = 1'b1;
    cur_en = 3'b000;  cur_cnt = 25'd1000;  cur_last = 1'b0;
    drive();
    model_reset();
    #10;
    chk("reset_d50",  if_d.pwm, 1'b0);
    chk("reset_d0",   if_z.pwm, 1'b0);
    chk("reset_d100", if_f.pwm, 1'b0);

    // release reset with 101 already applied: first edge sees pcnt 0 and triggers blanking
    @(posedge clk);
    nRst = 1'b0;
    cur_en = 3'b101;
    drive();
    model_step();
    repeat (30) cyc(3'b101, 25'd1000, 1'b0);

    // steady chopping: one full period holds exactly DUTY high samples
    hd = 0;  hz = 0;  hf = 0;
    for (int k = 0; k < PERIOD; k++) begin
      cyc(3'b101, 25'd1000, 1'b0);
      hd += int'(if_d.pwm);  hz += int'(if_z.pwm);  hf += int'(if_f.pwm);
    end
    chk_int("period_high_d50",  hd, 50);
    chk_int("period_high_d0",   hz, 0);
    chk_int("period_high_d100", hf, 100);

    // enable change in the high phase, then a second change inside the blanking window
    align(3'b101, 10);
    cyc(3'b011, 25'd1000, 1'b0);
    repeat (5) cyc(3'b011, 25'd1000, 1'b0);
    cyc(3'b110, 25'd1000, 1'b0);
    repeat (40) cyc(3'b110, 25'd1000, 1'b0);

    // end-of-step guard and last-cycle flag inside the high phase
    align(3'b110, 5);
    cyc(3'b110, 25'd5, 1'b0);
    cyc(3'b110, 25'd4, 1'b0);
    cyc(3'b110, 25'd3, 1'b0);
    cyc(3'b110, 25'd2, 1'b0);
    cyc(3'b110, 25'd1, 1'b1);
    cyc(3'b110, 25'd1000, 1'b1);
    repeat (5) cyc(3'b110, 25'd1000, 1'b0);

    // force stop mid high-phase, then restart
    align(3'b110, 20);
    repeat (20) cyc(3'b000, 25'd1000, 1'b0);
    repeat (30) cyc(3'b010, 25'd1000, 1'b0);

    // reset pulse mid high-phase
    align(3'b010, 15);
    reset_pulse();
    repeat (40) cyc(3'b010, 25'd1000, 1'b0);

    // randomized enables, step counts and last-cycle flags
    for (int i = 0; i < 2000; i++) begin
      logic [2:0]  en;
      logic [24:0] cnt;
      logic        l1;
      en  = ($urandom_range(0, 19) == 0) ? pats[$urandom_range(0, 6)] : cur_en;
      cnt = ($urandom_range(0, 3) == 0) ? 25'($urandom_range(0, 6))
                                        : 25'($urandom_range(7, 33554431));
      l1  = ($urandom_range(0, 15) == 0);
      if (i == 700 || i == 1400) reset_pulse();
      cyc(en, cnt, l1);
    end
    cyc(cur_en, 25'd1000, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/motoro3_pwm_generator.md
MOTORO3_PWM_GENERATOR -- requirements
Module: motoro3_pwm_generator

Interface
REQ-001 Parameter PERIOD, default 100, PWM period in clk cycles (100 kHz at 10 MHz clk); legal range 2..65535.
REQ-002 Parameter DUTY, default 50, clk cycles per period with pwm high; legal range 0..65535.
REQ-003 Parameter DEAD, default 10, blanking cycles after any phase-enable change; legal range 0..65535.
REQ-004 Parameter GUARD, default 2, pwm is suppressed while m3cnt <= GUARD (end-of-step guard).
REQ-005 clk  input  1  system clock, 10 MHz; all registers update on the falling edge.
REQ-006 nRst  input  1  reset; asynchronous, active-high.
REQ-007 aE  input  1  phase A bridge enable from the step decoder.
REQ-008 bE  input  1  phase B bridge enable.
REQ-009 cE  input  1  phase C bridge enable.
REQ-010 m3cnt  input  25  step down-counter value, unsigned.
REQ-011 m3cntLast1  input  1  high in the last cycle of a commutation step.
REQ-012 pwm  output  1  registered chopping signal for the enabled high-side switch.

Function
REQ-013 A 16-bit period counter pcnt SHALL count 0,1,...,PERIOD-1 and wrap to 0, free-running whenever reset is inactive.
REQ-014 An enable history register enPrev SHALL capture {aE,bE,cE} every cycle.
REQ-015 A 16-bit dead counter SHALL load DEAD when {aE,bE,cE} != enPrev, else decrement by 1 when nonzero, holding at 0.
REQ-016 An enable change while the dead counter is nonzero SHALL reload it to DEAD (restart blanking).
REQ-017 pwm_next SHALL be 1 only if all hold: (aE|bE|cE)=1, pcnt < DUTY, dead counter = 0, m3cntLast1 = 0, m3cnt > GUARD.
REQ-018 pwm SHALL be the registered pwm_next: exactly one clk cycle latency from the sampled inputs and pcnt.
REQ-019 Comparisons SHALL be unsigned; m3cnt is compared at full 25-bit width against GUARD zero-extended.
REQ-020 DUTY = 0 SHALL keep pwm at 0; DUTY >= PERIOD SHALL give pwm = 1 every cycle that the other conditions of REQ-017 hold.
REQ-021 {aE,bE,cE} = 000 (idle or force stop) SHALL drive pwm to 0 on the next falling edge, independent of every counter.
REQ-022 The block SHALL never drive pwm high during the cycle after m3cntLast1 was sampled high.
REQ-023 pwm SHALL be glitch-free: driven directly from a flip-flop, with no combinational output path.

Reset
REQ-024 While nRst = 1: pwm = 0, pcnt = 0, enPrev = 000, dead counter = 0, asynchronously and held.
REQ-025 On reset release, pcnt SHALL start at 0 on the first falling edge; a nonzero enable then triggers DEAD blanking, because enPrev = 000.
REQ-026 Reset asserted mid-period or mid-blanking SHALL immediately force pwm = 0 and discard all counter state.

Verification
REQ-027 Steady enable 101, m3cnt = 1000, m3cntLast1 = 0 after blanking -> pwm high 50 cycles, low 50 cycles, period exactly 100 cycles.
REQ-028 Enable 101 -> 011 -> pwm = 0 for 10 cycles after the change (plus 1-cycle latency), then chopping resumes at pcnt phase.
REQ-029 m3cnt counting down 5,4,3,2,1 with pcnt < DUTY -> pwm high for m3cnt 5,4,3 and low once m3cnt <= 2; pwm low the cycle after m3cntLast1 = 1.
REQ-030 Enable forced to 000 mid high-phase -> pwm = 0 one cycle later and stays 0.
REQ-031 Parameter sweep DUTY = 0 and DUTY = 100 (PERIOD = 100) -> pwm constantly 0, and constantly 1 outside the guard/blanking windows.
REQ-032 nRst pulsed high mid high-phase -> pwm = 0 immediately, before any clk edge; after release pcnt restarts at 0 and 10 blanking cycles follow.
